pll_lock_supervisor: RTL

- Consumer end of the PLL lock/reset interface.
- Samples the PLL's asynchronous lock output and drives the PLL's active-low reset input.
- Releases the downstream system reset only after lock has been stable for a programmable window.
- Re-arms the PLL after lock loss or lock timeout, and counts lock-loss events. Runs on the PLL reference clock, which stays valid while the PLL is unlocked.

---
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and downstream reset release
module pll_lock_supervisor #(
   parameter int SYNC_STAGES        = 2,
   parameter int PLL_RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT       = 100000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CNT_W              = 8
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             locked_in,
   output logic             pll_resetb,
   output logic             sys_reset,
   output logic             ready,
   output logic [CNT_W-1:0] loss_count,
   output logic             timeout_seen
);

   // The shared counter must reach the largest terminal value of any state.
   localparam int MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
   localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CTR_W-1:0] RST_LAST     = CTR_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT - 1);
   localparam logic [CTR_W-1:0] STABLE_LAST  = CTR_W'(LOCK_STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CTR_W-1:0]       ctr_q, ctr_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pll_resetb_q, pll_resetb_d;
   logic                   sys_reset_q, sys_reset_d;
   logic                   ready_q, ready_d;
   logic [CNT_W-1:0]       loss_count_q, loss_count_d;
   logic                   timeout_seen_q, timeout_seen_d;
   logic                   locked_sync;

   assign locked_sync = sync_q[SYNC_STAGES-1];

   // Next-state, counter, synchronizer shift and registered-output computation.
   always_comb begin
      state_d        = state_q;
      ctr_d          = ctr_q + CTR_W'(1);
      sync_d         = {sync_q[SYNC_STAGES-2:0], locked_in};
      loss_count_d   = loss_count_q;
      timeout_seen_d = timeout_seen_q;

      case (state_q)
         PLL_RST: begin
            if (ctr_q == RST_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (locked_sync) begin
               state_d = STABLE;
            end else if (ctr_q == TIMEOUT_LAST) begin
               state_d        = PLL_RST;
               timeout_seen_d = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
            end else if (ctr_q == STABLE_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!locked_sync) begin
               state_d = PLL_RST;
               if (!(&loss_count_q)) begin
                  loss_count_d = loss_count_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = PLL_RST;
         end
      endcase

      if (state_d != state_q) begin
         ctr_d = '0;
      end

      // Outputs follow the next state so they change on the same edge as the state register.
      pll_resetb_d = (state_d != PLL_RST);
      sys_reset_d  = (state_d != RUN);
      ready_d      = (state_d == RUN);
   end

   // All state and outputs, cleared asynchronously by reset.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_q        <= PLL_RST;
         ctr_q          <= '0;
         sync_q         <= '0;
         pll_resetb_q   <= 1'b0;
         sys_reset_q    <= 1'b1;
         ready_q        <= 1'b0;
         loss_count_q   <= '0;
         timeout_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ctr_q          <= ctr_d;
         sync_q         <= sync_d;
         pll_resetb_q   <= pll_resetb_d;
         sys_reset_q    <= sys_reset_d;
         ready_q        <= ready_d;
         loss_count_q   <= loss_count_d;
         timeout_seen_q <= timeout_seen_d;
      end
   end

   assign pll_resetb   = pll_resetb_q;
   assign sys_reset    = sys_reset_q;
   assign ready        = ready_q;
   assign loss_count   = loss_count_q;
   assign timeout_seen = timeout_seen_q;

endmodule
